// File: rtl/display_pkg.sv
// Shared definitions for the display scan controller and its BCD conversion
// engine: blank code, digit count, largest displayable value, FSM state type
// and the BCD nibble type.
package display_pkg;

  localparam logic [4:0] BLANK_CODE = 5'd31;
  localparam int         NUM_DIGITS = 4;
  localparam int         MAX_DISP   = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (control only)
//   start      : begin a conversion of bin (accepted in IDLE or DONE)
//   bin        : binary value to convert
//   busy       : conversion in progress (SHIFT or DONE)
//   done       : high for the single DONE cycle; bcd/ovf valid then
//   ovf        : converted value exceeds MAX_DISP
//   bcd        : four BCD digits, index 0 = least significant
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [VALUE_W-1:0]            bin,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output bcd_t [NUM_DIGITS-1:0]         bcd
);

  localparam int                CNT_W    = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(VALUE_W - 1);
  localparam int                BCD_W    = 4 * NUM_DIGITS;

  scan_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [VALUE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic               ovf_q;
  logic               accept;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly
  // into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: loaded on every accepted start, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_sr <= bin;
      bcd_sr <= '0;
      cnt    <= '0;
      ovf_q  <= (32'(bin) > 32'(MAX_DISP));
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= {add3_adjust(bcd_sr), bin_sr} << 1;
      cnt              <= cnt + CNT_W'(1);
    end
  end

  assign bcd = bcd_sr;
  assign ovf = ovf_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Binary value -> 4-digit multiplexed 7-segment feed. Converts loaded values
// to BCD, holds them in a display register that only changes atomically at
// the end of a conversion, and scans one digit per refresh slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   value      : binary value to display
//   load       : one-cycle strobe sampling value (queued 1-deep if busy)
//   digit_code : digit 0-9 for the shared decoder, or BLANK_CODE
//   anode_n    : active-low digit enable, bit0 = rightmost digit
//   busy       : conversion in progress
//   ovf        : last converted value exceeded 9999 (display blanked)
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic [4:0]         digit_code,
  output logic [3:0]         anode_n,
  output logic               busy,
  output logic               ovf
);

  localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic                     conv_start, conv_busy, conv_done, conv_ovf;
  logic [VALUE_W-1:0]       conv_bin;
  bcd_t [NUM_DIGITS-1:0]    conv_bcd;

  logic                     pend_vld;
  logic [VALUE_W-1:0]       pend_val;
  logic                     pend_wr;

  logic [NUM_DIGITS-1:0][4:0] disp_q, disp_nxt;
  logic [DIV_W-1:0]           div_q, div_nxt;
  logic [1:0]                 slot_q, slot_nxt;
  logic [4:0]                 code_sel, code_nxt;
  logic [3:0]                 anode_nxt;
  logic                       slot_blank;

  // True for slots above 0 whose digit and every more significant digit are 0.
  function automatic logic lz_blank(input logic [NUM_DIGITS-1:0][4:0] c,
                                    input logic [1:0] s);
    logic z;
    z = (s != 2'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((2'(i) >= s) && (c[i] != 5'd0)) z = 1'b0;
    end
    return z;
  endfunction

  // A load in the DONE cycle is newer than anything pending, so it wins and
  // starts directly; otherwise the pending value restarts the engine at DONE.
  assign conv_start = (load && (!conv_busy || conv_done)) || (conv_done && pend_vld);
  assign conv_bin   = load ? value : pend_val;
  assign pend_wr    = load && conv_busy && !conv_done;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .ovf   (conv_ovf),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pend_vld <= 1'b0;
    else if (pend_wr)   pend_vld <= 1'b1;
    else if (conv_done) pend_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (pend_wr) pend_val <= value;
  end

  always_comb begin
    disp_nxt = disp_q;
    if (conv_done) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_nxt[i] = conv_ovf ? BLANK_CODE : {1'b0, conv_bcd[i]};
      end
    end
    div_nxt  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    slot_nxt = (div_q == DIV_LAST) ? slot_q + 2'd1 : slot_q;
  end

  // Outputs are registered from next-state values so a freshly written
  // display appears on the very edge that writes it.
  always_comb begin
    code_sel   = disp_nxt[slot_nxt];
    slot_blank = (code_sel == BLANK_CODE) ||
                 ((BLANK_LZ != 0) && lz_blank(disp_nxt, slot_nxt));
    anode_nxt  = slot_blank ? 4'b1111 : ~(4'b0001 << slot_nxt);
    code_nxt   = slot_blank ? BLANK_CODE : code_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      div_q      <= '0;
      slot_q     <= 2'd0;
      digit_code <= 5'd0;
      anode_n    <= 4'b1110;
      ovf        <= 1'b0;
    end else begin
      disp_q     <= disp_nxt;
      div_q      <= div_nxt;
      slot_q     <= slot_nxt;
      digit_code <= code_nxt;
      anode_n    <= anode_nxt;
      if (conv_done) ovf <= conv_ovf;
    end
  end

  assign busy = conv_busy;

endmodule
